// File: rtl/psram_acq_sequencer.sv
// -----------------------------------------------------------------------------
// psram_acq_sequencer
//
// Buffers 16-bit acquisition samples in a small FIFO and drains them into the
// PSRAM controller as sequential single-word QPI writes. It also services
// single-word readback requests from the host side. Everything runs in the
// mem_clk (PSRAM) domain.
//
// Optional feature macro: PSRAM_TIMEOUT_EN
//   defined   : a 6-bit watchdog aborts a PSRAM op that has not completed
//               TIMEOUT_CYCLES cycles after ISSUE. Error is sticky.
//   undefined : no watchdog, error is tied 0, WAIT lasts until endcommand.
//
// Ports
//   mem_clk, rst_n          clock, asynchronous active-low reset
//   sample_valid/_data      sample input, one word per cycle
//   fifo_full               FIFO full (registered); offered samples are dropped
//   overflow                sticky, a sample was dropped
//   rd_req, rd_addr         readback request pulse and byte address (bit 0 ignored)
//   rd_busy                 readback pending or in progress
//   rd_valid, rd_data       one-cycle readback result
//   wr_addr                 next write byte address
//   wrapped                 sticky, wr_addr wrapped from ADDR_LAST to 0
//   qpi_on, endcommand,
//   psram_data_out          status/data from the psram controller
//   address, read_write,
//   quad_start, data_in     command to the psram controller (1=write, 2=read)
//   error                   sticky watchdog error
// -----------------------------------------------------------------------------
module psram_acq_sequencer #(
   parameter int          FIFO_DEPTH     = 16,
   parameter logic [22:0] ADDR_LAST      = 23'h7FFFFE,
   parameter int          GUARD_CYCLES   = 3,
   parameter int          TIMEOUT_CYCLES = 63
) (
   input  logic        mem_clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [15:0] sample_data,
   output logic        fifo_full,
   output logic        overflow,
   input  logic        rd_req,
   input  logic [22:0] rd_addr,
   output logic        rd_busy,
   output logic        rd_valid,
   output logic [15:0] rd_data,
   output logic [22:0] wr_addr,
   output logic        wrapped,
   input  logic        qpi_on,
   input  logic        endcommand,
   input  logic [15:0] psram_data_out,
   output logic [22:0] address,
   output logic [1:0]  read_write,
   output logic        quad_start,
   output logic [15:0] data_in,
   output logic        error
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_ISSUE,
      ST_GUARD,
      ST_WAIT,
      ST_RD_DONE
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [15:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             fifo_full_reg;
   logic             overflow_reg;
   logic             push;
   logic             pop;

   state_t           state_reg;
   logic             op_write_reg;

   // Full is judged on the registered flag, i.e. before any pop this cycle,
   // so a push that coincides with a pop while full is still dropped.
   assign push = sample_valid && !fifo_full_reg;
   // The head word was already copied into data_in on entry to ISSUE; the
   // entry is released during the ISSUE cycle.
   assign pop  = (state_reg == ST_ISSUE) && op_write_reg;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Storage has no reset so it can map onto plain RAM.
   always_ff @(posedge mem_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= sample_data;
      end
   end

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         fifo_full_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg     <= count_next;
         fifo_full_reg <= (count_next == CNT_W'(FIFO_DEPTH));
         if (sample_valid && fifo_full_reg) overflow_reg <= 1'b1;
      end
   end

   // ------------------------------------------------------------ sequencer
   logic [22:0]      wr_addr_reg;
   logic             wrapped_reg;
   logic [22:0]      rd_addr_lat_reg;
   logic             rd_pend_reg;
   logic             rd_busy_reg;
   logic             rd_valid_reg;
   logic [15:0]      rd_data_reg;
   logic [22:0]      address_reg;
   logic [1:0]       read_write_reg;
   logic             quad_start_reg;
   logic [15:0]      data_in_reg;
   logic [GRD_W-1:0] guard_cnt_reg;
`ifdef PSRAM_TIMEOUT_EN
   localparam int WD_W = 6;
   logic [WD_W-1:0]  wd_cnt_reg;
   logic             error_reg;
`endif

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_INIT;
         op_write_reg    <= 1'b0;
         wr_addr_reg     <= '0;
         wrapped_reg     <= 1'b0;
         rd_addr_lat_reg <= '0;
         rd_pend_reg     <= 1'b0;
         rd_busy_reg     <= 1'b0;
         rd_valid_reg    <= 1'b0;
         rd_data_reg     <= '0;
         address_reg     <= '0;
         read_write_reg  <= 2'd0;
         quad_start_reg  <= 1'b0;
         data_in_reg     <= '0;
         guard_cnt_reg   <= '0;
`ifdef PSRAM_TIMEOUT_EN
         wd_cnt_reg      <= '0;
         error_reg       <= 1'b0;
`endif
      end else begin
         quad_start_reg <= 1'b0;
         rd_valid_reg   <= 1'b0;

         // A request is accepted only when no readback is outstanding; the
         // clear of rd_busy below never coincides with an accept.
         if (rd_req && !rd_busy_reg) begin
            rd_addr_lat_reg <= rd_addr & ~23'd1;
            rd_pend_reg     <= 1'b1;
            rd_busy_reg     <= 1'b1;
         end

         case (state_reg)
            ST_INIT: begin
               if (qpi_on) state_reg <= ST_IDLE;
            end

            ST_IDLE: begin
               if (!qpi_on) begin
                  state_reg <= ST_INIT;
               end else if (fifo_full_reg || (!rd_pend_reg && count_reg != '0)) begin
                  state_reg      <= ST_ISSUE;
                  op_write_reg   <= 1'b1;
                  address_reg    <= wr_addr_reg;
                  data_in_reg    <= fifo_mem[rd_ptr_reg];
                  read_write_reg <= 2'd1;
                  quad_start_reg <= 1'b1;
               end else if (rd_pend_reg) begin
                  state_reg      <= ST_ISSUE;
                  op_write_reg   <= 1'b0;
                  address_reg    <= rd_addr_lat_reg;
                  read_write_reg <= 2'd2;
                  quad_start_reg <= 1'b1;
                  rd_pend_reg    <= 1'b0;
               end
            end

            ST_ISSUE: begin
               guard_cnt_reg <= '0;
`ifdef PSRAM_TIMEOUT_EN
               wd_cnt_reg    <= '0;
`endif
               state_reg     <= ST_GUARD;
            end

            // endcommand may still reflect the previous op right after
            // quad_start, so it is not looked at here.
            ST_GUARD: begin
`ifdef PSRAM_TIMEOUT_EN
               wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
`endif
               if (guard_cnt_reg == GRD_W'(GUARD_CYCLES - 1)) begin
                  state_reg <= ST_WAIT;
               end else begin
                  guard_cnt_reg <= guard_cnt_reg + GRD_W'(1);
               end
            end

            ST_WAIT: begin
               if (endcommand) begin
                  read_write_reg <= 2'd0;
                  if (op_write_reg) begin
                     if (wr_addr_reg == ADDR_LAST) begin
                        wr_addr_reg <= '0;
                        wrapped_reg <= 1'b1;
                     end else begin
                        wr_addr_reg <= wr_addr_reg + 23'd2;
                     end
                     state_reg <= qpi_on ? ST_IDLE : ST_INIT;
                  end else begin
                     rd_data_reg  <= psram_data_out;
                     rd_valid_reg <= 1'b1;
                     rd_busy_reg  <= 1'b0;
                     state_reg    <= ST_RD_DONE;
                  end
`ifdef PSRAM_TIMEOUT_EN
               end else if (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  // Abort: a write word is lost (already popped) and the
                  // address is not advanced; a read returns a marker word.
                  read_write_reg <= 2'd0;
                  error_reg      <= 1'b1;
                  if (!op_write_reg) begin
                     rd_data_reg  <= 16'hDEAD;
                     rd_valid_reg <= 1'b1;
                     rd_busy_reg  <= 1'b0;
                  end
                  state_reg <= ST_IDLE;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
`endif
               end
            end

            ST_RD_DONE: begin
               state_reg <= qpi_on ? ST_IDLE : ST_INIT;
            end

            default: state_reg <= ST_INIT;
         endcase
      end
   end

   assign fifo_full  = fifo_full_reg;
   assign overflow   = overflow_reg;
   assign rd_busy    = rd_busy_reg;
   assign rd_valid   = rd_valid_reg;
   assign rd_data    = rd_data_reg;
   assign wr_addr    = wr_addr_reg;
   assign wrapped    = wrapped_reg;
   assign address    = address_reg;
   assign read_write = read_write_reg;
   assign quad_start = quad_start_reg;
   assign data_in    = data_in_reg;
`ifdef PSRAM_TIMEOUT_EN
   assign error      = error_reg;
`else
   assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_psram_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_psram_acq_sequencer
//
// Directed bench for psram_acq_sequencer (ADDR_LAST reduced to 6 so address
// wrap is reached quickly). A small psram model logs every command issued on
// quad_start and answers with endcommand a programmable number of cycles
// later, or holds endcommand high continuously.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_psram_acq_sequencer;

   logic        mem_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_data = '0;
   logic        fifo_full;
   logic        overflow;
   logic        rd_req = 1'b0;
   logic [22:0] rd_addr = '0;
   logic        rd_busy;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic [22:0] wr_addr;
   logic        wrapped;
   logic        qpi_on = 1'b0;
   logic        endcommand;
   logic [15:0] psram_data_out = '0;
   logic [22:0] address;
   logic [1:0]  read_write;
   logic        quad_start;
   logic [15:0] data_in;
   logic        error;

   always #6 mem_clk = ~mem_clk;

   psram_acq_sequencer #(
      .FIFO_DEPTH     (16),
      .ADDR_LAST      (23'h000006),
      .GUARD_CYCLES   (3),
      .TIMEOUT_CYCLES (63)
   ) dut (
      .mem_clk        (mem_clk),
      .rst_n          (rst_n),
      .sample_valid   (sample_valid),
      .sample_data    (sample_data),
      .fifo_full      (fifo_full),
      .overflow       (overflow),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_busy        (rd_busy),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .wr_addr        (wr_addr),
      .wrapped        (wrapped),
      .qpi_on         (qpi_on),
      .endcommand     (endcommand),
      .psram_data_out (psram_data_out),
      .address        (address),
      .read_write     (read_write),
      .quad_start     (quad_start),
      .data_in        (data_in),
      .error          (error)
   );

   // ------------------------------------------------------------ checking
   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
         $display("ok   %-16s got=%0h", tag, got);
      end else begin
         $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------- psram model
   int          ec_delay = 8;     // 0 = never answer
   bit          ec_hold  = 1'b0;  // endcommand stuck high
   int          ec_timer = 0;
   int          cyc = 0;
   int          qs_cyc = 0;
   int          last_rw_cyc = 0;
   int          rv_cnt = 0;
   int          hold_err = 0;
   logic [15:0] rv_data = '0;
   logic [22:0] cur_addr = '0;
   logic [15:0] cur_data = '0;
   logic [1:0]  cur_rw = '0;
   logic [22:0] op_addr [$];
   logic [15:0] op_data [$];
   logic [1:0]  op_rw   [$];

   assign endcommand = ec_hold || (ec_timer == 1);

   always @(posedge mem_clk) begin
      cyc <= cyc + 1;
      if (quad_start) begin
         op_addr.push_back(address);
         op_data.push_back(data_in);
         op_rw.push_back(read_write);
         cur_addr <= address;
         cur_data <= data_in;
         cur_rw   <= read_write;
         qs_cyc   <= cyc;
         ec_timer <= ec_delay;
      end else if (ec_timer > 0) begin
         ec_timer <= ec_timer - 1;
      end
      if (read_write != 2'd0) begin
         last_rw_cyc <= cyc;
         if (!quad_start && (address !== cur_addr || read_write !== cur_rw ||
                             (cur_rw == 2'd1 && data_in !== cur_data)))
            hold_err <= hold_err + 1;
      end
      if (rd_valid) begin
         rv_cnt  <= rv_cnt + 1;
         rv_data <= rd_data;
      end
   end

   // ------------------------------------------------------------- helpers
   task automatic push_words(input logic [15:0] base, input logic [15:0] step, input int n);
      for (int i = 0; i < n; i++) begin
         sample_valid = 1'b1;
         sample_data  = base + 16'(i) * step;
         @(negedge mem_clk);
      end
      sample_valid = 1'b0;
   endtask

   task automatic wait_done(input int nops, input int budget, input string tag);
      int n = 0;
      while (!(op_addr.size() >= nops && read_write == 2'd0 && ec_timer == 0) && n < budget) begin
         @(negedge mem_clk);
         n++;
      end
      check_eq({tag, "_done"}, 32'(n < budget), 32'd1);
      repeat (2) @(negedge mem_clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench did not finish");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [22:0] saved_addr;
      saved_addr = '0;
      repeat (3) @(negedge mem_clk);
      rst_n = 1'b1;
      @(negedge mem_clk);

      check_eq("rst_fifo_full",  fifo_full,  0);
      check_eq("rst_overflow",   overflow,   0);
      check_eq("rst_rd_busy",    rd_busy,    0);
      check_eq("rst_wr_addr",    wr_addr,    0);
      check_eq("rst_read_write", read_write, 0);
      check_eq("rst_quad_start", quad_start, 0);
      check_eq("rst_error",      error,      0);

      // writes held off until qpi_on
      push_words(16'h1111, 16'h1111, 3);
      repeat (10) @(negedge mem_clk);
      check_eq("init_no_ops", op_addr.size(), 0);
      qpi_on = 1'b1;
      wait_done(3, 300, "t1");
      for (int j = 0; j < 3; j++) begin
         check_eq($sformatf("t1_addr%0d", j), op_addr[j], 2 * j);
         check_eq($sformatf("t1_data%0d", j), op_data[j], 16'h1111 * (j + 1));
         check_eq($sformatf("t1_rw%0d", j),   op_rw[j],   1);
      end
      check_eq("t1_wr_addr", wr_addr, 6);
      check_eq("t1_wrapped", wrapped, 0);

      // wrap: writes at 6 then 0
      push_words(16'h4444, 16'h1111, 2);
      wait_done(5, 300, "wrap");
      check_eq("wrap_addr3", op_addr[3], 6);
      check_eq("wrap_addr4", op_addr[4], 0);
      check_eq("wrap_data4", op_data[4], 16'h5555);
      check_eq("wrap_flag",  wrapped,    1);
      check_eq("wrap_wr_addr", wr_addr,  2);

      // readback; a second request while busy is ignored
      psram_data_out = 16'hBEEF;
      rd_addr = 23'h000013;
      rd_req  = 1'b1;
      @(negedge mem_clk);
      rd_req  = 1'b0;
      check_eq("rd_busy_set", rd_busy, 1);
      rd_addr = 23'h000040;
      rd_req  = 1'b1;
      @(negedge mem_clk);
      rd_req  = 1'b0;
      wait_done(6, 300, "rd");
      check_eq("rd_addr",    op_addr[5], 23'h12);
      check_eq("rd_rw",      op_rw[5],   2);
      check_eq("rd_valid_n", rv_cnt,     1);
      check_eq("rd_data",    rv_data,    16'hBEEF);
      check_eq("rd_busy_clr", rd_busy,   0);
      repeat (20) @(negedge mem_clk);
      check_eq("rd_ignored", op_addr.size(), 6);

      // endcommand stuck high: completes in the 4th cycle after quad_start
      ec_delay = 0;
      ec_hold  = 1'b1;
      push_words(16'h6666, 16'h0000, 1);
      wait_done(7, 300, "hold");
      check_eq("hold_len",  last_rw_cyc - qs_cyc, 4);
      check_eq("hold_addr", op_addr[6], 2);
      check_eq("hold_data", op_data[6], 16'h6666);
      ec_hold = 1'b0;
      check_eq("hold_wr_addr", wr_addr, 4);

      // overflow: 20 samples, 17 accepted (s0..s16), s17..s19 dropped
      ec_delay = 20;
      check_eq("ovf_pre", overflow, 0);
      push_words(16'hA000, 16'h0001, 20);
      check_eq("ovf_full", fifo_full, 1);
      check_eq("ovf_flag", overflow,  1);
      wait_done(24, 2000, "ovf");
      repeat (40) @(negedge mem_clk);
      check_eq("ovf_ops", op_addr.size(), 24);
      for (int j = 0; j < 17; j++) begin
         check_eq($sformatf("ovf_data%0d", j), op_data[7 + j], 16'hA000 + 16'(j));
         check_eq($sformatf("ovf_addr%0d", j), op_addr[7 + j], ((2 + j) % 4) * 2);
      end
      check_eq("ovf_full_clr", fifo_full, 0);
      check_eq("ovf_wr_addr",  wr_addr,   6);

`ifdef PSRAM_TIMEOUT_EN
      // no endcommand: watchdog fires, address not advanced, next op normal
      ec_delay   = 0;
      saved_addr = wr_addr;
      push_words(16'h7777, 16'h0000, 1);
      wait_done(25, 300, "wd");
      check_eq("wd_error",   error,   1);
      check_eq("wd_wr_addr", wr_addr, saved_addr);
      ec_delay = 8;
      push_words(16'h8888, 16'h0000, 1);
      wait_done(26, 300, "wd_next");
      check_eq("wd_next_addr", op_addr[25], saved_addr);
      check_eq("wd_next_data", op_data[25], 16'h8888);
      check_eq("wd_next_wr",   wr_addr,     0);
`endif

      check_eq("hold_stable", hold_err, 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
